// File: rtl/multi_clock_generator_pkg.sv
// Shared constants for the multi-channel clock divider: channel limits, output
// mode codes and the standard divisors for a 100 MHz crystal.
package multi_clock_generator_pkg;

  localparam int unsigned MAX_CH = 8;
  localparam int unsigned SEL_W  = 3;

  typedef enum logic {
    ModeSquare = 1'b0,
    ModePulse  = 1'b1
  } mode_e;

  localparam int unsigned DIV_BY_25M_W  = 25;
  localparam int unsigned DIV_BY_500K_W = 19;
  localparam logic [DIV_BY_25M_W-1:0]  DIV_BY_25M  = 25'd25000000;
  localparam logic [DIV_BY_500K_W-1:0] DIV_BY_500K = 19'd500000;

  function automatic logic sel_valid(input logic [SEL_W-1:0] sel, input int unsigned num_ch);
    return 32'(sel) < num_ch;
  endfunction

endpackage

// File: rtl/multi_clock_generator_clk_div_channel.sv
// One divider channel: counter, active/pending divisor pair and output mode.
// Divisor changes land only on a period boundary, on sync, or while disabled.
module multi_clock_generator_clk_div_channel
  import multi_clock_generator_pkg::*;
#(
  parameter int unsigned          CNT_WIDTH   = 26,
  parameter logic [CNT_WIDTH-1:0] DEFAULT_DIV = '1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic                 i_mode,
  input  logic                 i_sync,
  input  logic                 i_wr,
  input  logic [CNT_WIDTH-1:0] i_data,
  output logic                 o_clk_out,
  output logic                 o_tick,
  output logic                 o_pending
);

  logic [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0] r_active;
  logic [CNT_WIDTH-1:0] r_pending;
  logic                 r_pend_flag;
  logic                 r_clk_out;
  logic                 r_tick;

  logic [CNT_WIDTH-1:0] w_last;
  logic                 w_tc;
  mode_e                w_mode;

  // A divisor of 0 behaves as 1; '>=' keeps the counter self-recovering.
  assign w_last = (r_active == '0) ? '0 : r_active - 1'b1;
  assign w_tc   = (r_count >= w_last);
  assign w_mode = mode_e'(i_mode);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count     <= '0;
      r_active    <= DEFAULT_DIV;
      r_pending   <= DEFAULT_DIV;
      r_pend_flag <= 1'b0;
      r_clk_out   <= 1'b0;
      r_tick      <= 1'b0;
    end else if (i_sync) begin
      r_count     <= '0;
      r_clk_out   <= 1'b0;
      r_tick      <= 1'b0;
      r_pend_flag <= 1'b0;
      if (i_wr) begin
        r_active  <= i_data;
        r_pending <= i_data;
      end else if (r_pend_flag) begin
        r_active <= r_pending;
      end
    end else if (i_en) begin
      r_tick <= w_tc;
      if (w_tc) begin
        r_count     <= '0;
        r_clk_out   <= (w_mode == ModePulse) ? 1'b1 : ~r_clk_out;
        r_pend_flag <= 1'b0;
        // A write coinciding with the boundary goes straight to active.
        if (i_wr) begin
          r_active  <= i_data;
          r_pending <= i_data;
        end else if (r_pend_flag) begin
          r_active <= r_pending;
        end
      end else begin
        r_count <= r_count + 1'b1;
        if (w_mode == ModePulse) begin
          r_clk_out <= 1'b0;
        end
        if (i_wr) begin
          r_pending   <= i_data;
          r_pend_flag <= 1'b1;
        end
      end
    end else begin
      r_tick <= 1'b0;
      if (i_wr) begin
        r_pending   <= i_data;
        r_pend_flag <= 1'b1;
      end else if (r_pend_flag) begin
        r_active    <= r_pending;
        r_pend_flag <= 1'b0;
      end
    end
  end

  assign o_clk_out = r_clk_out;
  assign o_tick    = r_tick;
  assign o_pending = r_pend_flag;

endmodule

// File: rtl/multi_clock_generator.sv
// NUM_CH independent programmable clock dividers with per-channel strobes.
// Decodes divisor writes by channel and fans sync_all out to every channel.
module multi_clock_generator
  import multi_clock_generator_pkg::*;
#(
  parameter int unsigned                     NUM_CH      = 2,
  parameter int unsigned                     CNT_WIDTH   = 26,
  parameter logic [NUM_CH*CNT_WIDTH-1:0]     DEFAULT_DIV = {26'd500000, 26'd25000000}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    en,
  input  logic [NUM_CH-1:0]    mode,
  input  logic                 sync_all,
  input  logic                 div_wr,
  input  logic [SEL_W-1:0]     div_sel,
  input  logic [CNT_WIDTH-1:0] div_data,
  output logic [NUM_CH-1:0]    clk_out,
  output logic [NUM_CH-1:0]    tick,
  output logic [NUM_CH-1:0]    div_pending
);

  logic              w_sel_ok;
  logic [NUM_CH-1:0] w_wr;

  // Out-of-range channel indices are dropped here so no channel sees them.
  assign w_sel_ok = sel_valid(div_sel, NUM_CH);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    assign w_wr[ch] = div_wr & w_sel_ok & (div_sel == SEL_W'(ch));

    multi_clock_generator_clk_div_channel #(
      .CNT_WIDTH   (CNT_WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV[ch*CNT_WIDTH +: CNT_WIDTH])
    ) u_clk_div_channel (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_en      (en[ch]),
      .i_mode    (mode[ch]),
      .i_sync    (sync_all),
      .i_wr      (w_wr[ch]),
      .i_data    (div_data),
      .o_clk_out (clk_out[ch]),
      .o_tick    (tick[ch]),
      .o_pending (div_pending[ch])
    );
  end

endmodule
